cordic_controller: RTL
======================

// Module: cordic_controller
// PURPOSE
//  Sequencer for an iterative (single shared-stage) rotation-mode CORDIC: sin/cos of angle_in (Q4.12, [0,2*PI)).
//  Accepts one angle per valid/ready transaction and maps it to [-PI/2,PI/2] via an instantiated quadrant_mapper.
//  Runs N shift-add micro-iterations on one adder set, applies quadrant sign fixes, presents sin/cos on a valid/ready output.
//  Sits between the angle source (NCO/phase accumulator) and downstream DSP consumers.
// PARAMETERS
//  N_ITER  16  micro-iterations per conversion (1..16; atan LUT is 16 entries)
//  GUARD   2   extra LSB-side... no: extra MSB guard bits on internal x/y/z (internal width 16+GUARD)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  angle_in   in   16  unsigned Q4.12 angle, legal range 0..25735 (2*PI = 25736)
//  in_valid   in   1   angle_in valid
//  in_ready   out  1   controller can accept an angle (high only in IDLE)
//  sin_out    out  16  signed Q4.12 sine
//  cos_out    out  16  signed Q4.12 cosine
//  err_out    out  1   angle_in >= 25736 for this result; sin/cos forced to 0
//  out_valid  out  1   result valid; held with data stable until out_ready
//  out_ready  in   1   consumer accepts result
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE, sin_out=cos_out=0, err_out=0, out_valid=0, iteration counter=0, flip regs=0.
//   in_ready=0 and busy=0 while rst=1. A reset mid-ITER/FIX/DONE aborts the conversion; no partial result is emitted.
//  FSM: IDLE -> ITER -> FIX -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready, register x=K_INV(2487), y=0, z=Z_init (sign-extended), flip_X/flip_Y, and
//    err=(angle_in>=25736); cnt=0; go ITER. If err, go directly to FIX (skip iterations).
//   ITER: one micro-rotation per cycle, i=cnt: d=+1 if z>=0 else -1;
//    x<=x-d*(y>>>i), y<=y+d*(x>>>i), z<=z-d*ATAN[i]; arithmetic shifts, two's complement, internal width 16+GUARD.
//    cnt increments each cycle; after the cycle with cnt==N_ITER-1 go FIX.
//   FIX: cos=flip_X?-x:x, sin=flip_Y?-y:y; saturate to [-4096,+4096] then truncate to 16 bits; err forces both to 0.
//    Register into sin_out/cos_out/err_out, set out_valid=1, go DONE.
//   DONE: hold outputs stable while out_valid&!out_ready (arbitrary back-pressure). On out_ready: out_valid<=0, go IDLE.
//  Latency: accept edge E -> out_valid high after edge E+N_ITER+1 (17 cycles at default); error path: E+1.
//   Minimum accept-to-accept spacing N_ITER+3 cycles. No pipelining/overlap: at most one conversion in flight.
//  in_valid while busy: ignored (in_ready=0); the source holds its angle until accepted.
//  Outputs change only on the FIX edge or on reset; sin_out/cos_out retain the last result in IDLE.
//  Boundaries: angle 0 -> Q1; PI/2(6434) -> Q2 path, z=6434; PI(12868) -> Q3, z=0; 3PI/2(19302) -> Q4, z=-6434;
//   25735 -> Q4, z=-1; 25736..65535 -> err.
//  Accuracy target: |error| <= 8 LSB on sin and cos for all legal angles at N_ITER=16.
// STRUCTURE
//  Shared package cordic_pkg: Q4.12 constants PI_HALF=6434, PI_CONST=12868, PI_3_HALF=19302, PI_X2=25736, K_INV=2487;
//   ATAN LUT (Q4.12) {3217,1899,1003,509,256,128,64,32,16,8,4,2,1,1,0,0}; FSM state encoding.
//  One sub-module instance: quadrant_mapper (combinational, fed from angle_in; outputs sampled only on accept).
//  Datapath (x/y/z regs, shifters, add/sub, saturation) and FSM stay in this module; no further split.
// TESTING
//  1 angle_in=0, out_ready=1 -> out_valid 17 cycles after accept; cos_out=4096+-8, sin_out=0+-8, err_out=0.
//  2 angle_in=6434 then 12868 then 19302 -> (cos,sin)~=(0,4096), (-4096,0), (0,-4096), each +-8 LSB.
//  3 angle_in=25735 -> cos~=4096, sin~=-1+-8; angle_in=25736 -> err_out=1, sin=cos=0, out_valid 1 cycle after accept.
//  4 out_ready=0 for 20 cycles after out_valid -> outputs and out_valid stable, in_ready=0, busy=1; in_valid pulses
//    ignored; release -> IDLE next cycle, in_ready=1.
//  5 rst=1 for one edge during ITER (cnt=7) -> next cycle IDLE, out_valid=0, sin/cos=0; new angle 3217 converts
//    normally to (cos,sin)~=(2896,2896).
//  6 Random sweep of 1000 legal angles with random back-pressure vs real-valued model -> all within +-8 LSB,
//    no dropped/duplicated transactions.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM encoding for the iterative CORDIC sequencer.
package cordic_pkg;

  // Q4.12 angle landmarks (radians * 4096)
  localparam logic [15:0] PI_HALF   = 16'd6434;
  localparam logic [15:0] PI_CONST  = 16'd12868;
  localparam logic [15:0] PI_3_HALF = 16'd19302;
  localparam logic [15:0] PI_X2     = 16'd25736;

  // 1/K pre-scale so the rotated vector ends at unit magnitude (4096)
  localparam logic [15:0] K_INV = 16'd2487;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix,
    StDone
  } cordic_state_e;

  // atan(2^-i) in Q4.12
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    logic [15:0] val;
    case (idx)
      4'd0:    val = 16'd3217;
      4'd1:    val = 16'd1899;
      4'd2:    val = 16'd1003;
      4'd3:    val = 16'd509;
      4'd4:    val = 16'd256;
      4'd5:    val = 16'd128;
      4'd6:    val = 16'd64;
      4'd7:    val = 16'd32;
      4'd8:    val = 16'd16;
      4'd9:    val = 16'd8;
      4'd10:   val = 16'd4;
      4'd11:   val = 16'd2;
      4'd12:   val = 16'd1;
      4'd13:   val = 16'd1;
      default: val = 16'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_controller_quadrant_mapper.sv
// Folds a [0,2*PI) angle into [-PI/2,PI/2] and reports which output signs must be flipped.
module quadrant_mapper
  import cordic_pkg::*;
(
  input  logic        [15:0] angle_i,
  output logic signed [15:0] z_o,
  output logic               flip_x_o,
  output logic               flip_y_o,
  output logic               err_o
);

  // Quadrant select: Q2 reflects about PI/2, Q3 rotates by PI, Q4 wraps to a negative angle
  always_comb begin
    z_o      = '0;
    flip_x_o = 1'b0;
    flip_y_o = 1'b0;
    err_o    = (angle_i >= PI_X2);
    if (angle_i < PI_HALF) begin
      z_o = $signed(angle_i);
    end else if (angle_i < PI_CONST) begin
      z_o      = $signed(PI_CONST - angle_i);
      flip_x_o = 1'b1;
    end else if (angle_i < PI_3_HALF) begin
      z_o      = $signed(angle_i - PI_CONST);
      flip_x_o = 1'b1;
      flip_y_o = 1'b1;
    end else begin
      // Wraps modulo 2^16 into [-PI/2,0) for legal angles
      z_o = $signed(angle_i - PI_X2);
    end
  end

endmodule

// File: rtl/cordic_controller.sv
// Sequencer for a single-stage rotation-mode CORDIC producing sin/cos of a Q4.12 angle.
module cordic_controller
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = 16,
  parameter int unsigned GUARD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic        [15:0] angle_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] sin_out,
  output logic signed [15:0] cos_out,
  output logic               err_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int unsigned W = 16 + GUARD;
  localparam logic [3:0] CNT_LAST = 4'(N_ITER - 1);
  localparam logic signed [W-1:0] SAT_POS = W'(4096);
  localparam logic signed [W-1:0] SAT_NEG = -SAT_POS;

  cordic_state_e state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0] cnt_q, cnt_d;
  logic flip_x_q, flip_x_d, flip_y_q, flip_y_d, err_q, err_d;
  logic signed [15:0] sin_q, sin_d, cos_q, cos_d;
  logic err_out_q, err_out_d, out_valid_q, out_valid_d;

  logic signed [15:0] map_z;
  logic map_flip_x, map_flip_y, map_err;
  logic signed [W-1:0] shift_x, shift_y, atan_w, cos_full, sin_full;

  quadrant_mapper u_mapper (
    .angle_i  (angle_in),
    .z_o      (map_z),
    .flip_x_o (map_flip_x),
    .flip_y_o (map_flip_y),
    .err_o    (map_err)
  );

  // Clamp to the unit circle range, then keep the low 16 bits
  function automatic logic signed [15:0] sat16(input logic signed [W-1:0] v);
    if (v > SAT_POS) return 16'sd4096;
    if (v < SAT_NEG) return -16'sd4096;
    return v[15:0];
  endfunction

  // Next-state, datapath and output register updates
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    flip_x_d    = flip_x_q;
    flip_y_d    = flip_y_q;
    err_d       = err_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    err_out_d   = err_out_q;
    out_valid_d = out_valid_q;
    shift_x     = x_q >>> cnt_q;
    shift_y     = y_q >>> cnt_q;
    atan_w      = $signed({{GUARD{1'b0}}, atan_lut(cnt_q)});
    cos_full    = flip_x_q ? -x_q : x_q;
    sin_full    = flip_y_q ? -y_q : y_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d      = $signed({{GUARD{1'b0}}, K_INV});
          y_d      = '0;
          z_d      = {{GUARD{map_z[15]}}, map_z};
          flip_x_d = map_flip_x;
          flip_y_d = map_flip_y;
          err_d    = map_err;
          cnt_d    = '0;
          state_d  = map_err ? StFix : StIter;
        end
      end
      StIter: begin
        if (z_q[W-1]) begin
          x_d = x_q + shift_y;
          y_d = y_q - shift_x;
          z_d = z_q + atan_w;
        end else begin
          x_d = x_q - shift_y;
          y_d = y_q + shift_x;
          z_d = z_q - atan_w;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = StFix;
      end
      StFix: begin
        cos_d       = err_q ? 16'sd0 : sat16(cos_full);
        sin_d       = err_q ? 16'sd0 : sat16(sin_full);
        err_out_d   = err_q;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      flip_x_q    <= 1'b0;
      flip_y_q    <= 1'b0;
      err_q       <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
      err_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      flip_x_q    <= flip_x_d;
      flip_y_q    <= flip_y_d;
      err_q       <= err_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      err_out_q   <= err_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = !rst && (state_q == StIdle);
  assign busy      = !rst && (state_q != StIdle);
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign err_out   = err_out_q;
  assign out_valid = out_valid_q;

endmodule
